// File: rtl/vend_pkg.sv
// Shared definitions for the vending request sequencer: field widths,
// result codes, FSM state encoding and a small sizing helper.
package vend_pkg;

  localparam int DIGIT_W = 4;
  localparam int COST_W  = 3;

  typedef enum logic [1:0] {
    RES_VENDED  = 2'b00,
    RES_INVALID = 2'b01,
    RES_FAILED  = 2'b10,
    RES_TIMEOUT = 2'b11
  } result_e;

  typedef enum logic [3:0] {
    S_IDLE, S_CARD, S_GAP_C, S_KEY1, S_GAP_1, S_KEY2, S_GAP_2,
    S_WAIT_COST, S_AUTH, S_PAY, S_WAIT_VEND, S_DOOR_WAIT, S_DOOR, S_FINISH
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/vend_request_sequencer_if.sv
// Bundle of command, authorizer and machine-side signals of the sequencer.
// master: the sequencer itself; slave: host/authorizer/machine side.
interface vend_request_sequencer_if;
  import vend_pkg::*;

  logic               START;
  logic [DIGIT_W-1:0] TENS;
  logic [DIGIT_W-1:0] UNITS;
  logic               AUTH_VALID;
  logic               AUTH_OK;
  logic               TAKE_ITEM;
  logic               VEND;
  logic               INVALID_SEL;
  logic               FAILED_TRAN;
  logic [COST_W-1:0]  COST;
  logic               CARD_IN;
  logic               KEY_PRESS;
  logic               VALID_TRAN;
  logic               DOOR_OPEN;
  logic [DIGIT_W-1:0] ITEM_CODE;
  logic               AUTH_REQ;
  logic [COST_W-1:0]  AUTH_AMT;
  logic               BUSY;
  logic               DONE;
  logic [1:0]         RESULT;

  modport master (
    input  START, TENS, UNITS, AUTH_VALID, AUTH_OK, TAKE_ITEM,
           VEND, INVALID_SEL, FAILED_TRAN, COST,
    output CARD_IN, KEY_PRESS, VALID_TRAN, DOOR_OPEN, ITEM_CODE,
           AUTH_REQ, AUTH_AMT, BUSY, DONE, RESULT
  );

  modport slave (
    output START, TENS, UNITS, AUTH_VALID, AUTH_OK, TAKE_ITEM,
           VEND, INVALID_SEL, FAILED_TRAN, COST,
    input  CARD_IN, KEY_PRESS, VALID_TRAN, DOOR_OPEN, ITEM_CODE,
           AUTH_REQ, AUTH_AMT, BUSY, DONE, RESULT
  );
endinterface

// File: rtl/vseq_timer.sv
// Loadable down-counter shared by the gap, timeout and door delays.
// expired is high while the count sits at zero.
module vseq_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Reload on request, otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/vend_request_sequencer.sv
// Vending machine request sequencer: turns one START command into the
// card/key/payment/door pulse sequence and classifies the outcome.
// Build option VSEQ_AUTO_DOOR_EN: door opens DOOR_DELAY cycles after VEND
// instead of waiting for TAKE_ITEM.
// Every wait state lasts at most TIMEOUT_CYCLES+1 cycles; a response seen in
// the last cycle still wins over the timeout.
module vend_request_sequencer
  import vend_pkg::*;
#(
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 12,
  parameter int DOOR_DELAY     = 2
) (
  input logic                     CLK,
  input logic                     RESET,
  vend_request_sequencer_if.master bus
);

  localparam int TMR_MAX  = max3(TIMEOUT_CYCLES, DOOR_DELAY, GAP_CYCLES);
  localparam int TMR_W    = $clog2(TMR_MAX + 1);
  localparam int GAP_LOAD = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;
`ifdef VSEQ_AUTO_DOOR_EN
  localparam int DOOR_LOAD = (DOOR_DELAY > 1) ? DOOR_DELAY - 1 : 0;
`endif

  state_e             state_q, state_d;
  result_e            result_q, result_d;
  logic [DIGIT_W-1:0] tens_q, tens_d, units_q, units_d;
  logic [DIGIT_W-1:0] item_code_q, item_code_d;
  logic [COST_W-1:0]  auth_amt_q, auth_amt_d;
  logic card_in_q, card_in_d, key_press_q, key_press_d;
  logic valid_tran_q, valid_tran_d, door_open_q, door_open_d;
  logic auth_req_q, auth_req_d, busy_q, busy_d, done_q, done_d;

  logic             tmr_load, tmr_expired;
  logic [TMR_W-1:0] tmr_val;

  vseq_timer #(.WIDTH(TMR_W)) u_timer (
    .clk(CLK), .rst(RESET), .load(tmr_load), .load_val(tmr_val), .expired(tmr_expired)
  );

  // Next state, latched data and result
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    tens_d     = tens_q;
    units_d    = units_q;
    auth_amt_d = auth_amt_q;
    unique case (state_q)
      S_IDLE: if (bus.START) begin
        state_d  = S_CARD;
        tens_d   = bus.TENS;
        units_d  = bus.UNITS;
        result_d = RES_VENDED;
      end
      S_CARD:  state_d = S_GAP_C;
      S_GAP_C: if (tmr_expired) state_d = S_KEY1;
      S_KEY1:  state_d = S_GAP_1;
      S_GAP_1: if (tmr_expired) state_d = S_KEY2;
      S_KEY2:  state_d = S_GAP_2;
      S_GAP_2: if (tmr_expired) state_d = S_WAIT_COST;
      S_WAIT_COST: begin
        if (bus.INVALID_SEL) begin
          result_d = RES_INVALID; state_d = S_FINISH;
        end else if (bus.FAILED_TRAN) begin
          result_d = RES_FAILED; state_d = S_FINISH;
        end else if (bus.COST != '0) begin
          auth_amt_d = bus.COST; state_d = S_AUTH;
        end else if (tmr_expired) begin
          result_d = RES_TIMEOUT; state_d = S_FINISH;
        end
      end
      S_AUTH: begin
        if (bus.FAILED_TRAN) begin
          result_d = RES_FAILED; state_d = S_FINISH;
        end else if (bus.AUTH_VALID) begin
          // A declined payment sends nothing; the machine reports the failure
          state_d = bus.AUTH_OK ? S_PAY : S_WAIT_VEND;
        end else if (tmr_expired) begin
          result_d = RES_TIMEOUT; state_d = S_FINISH;
        end
      end
      S_PAY: begin
        if (bus.FAILED_TRAN) begin
          result_d = RES_FAILED; state_d = S_FINISH;
        end else begin
          state_d = S_WAIT_VEND;
        end
      end
      S_WAIT_VEND: begin
        if (bus.FAILED_TRAN) begin
          result_d = RES_FAILED; state_d = S_FINISH;
        end else if (bus.VEND) begin
          state_d = S_DOOR_WAIT;
        end else if (tmr_expired) begin
          result_d = RES_TIMEOUT; state_d = S_FINISH;
        end
      end
      S_DOOR_WAIT: begin
`ifdef VSEQ_AUTO_DOOR_EN
        if (tmr_expired) state_d = S_DOOR;
`else
        if (bus.TAKE_ITEM) begin
          state_d = S_DOOR;
        end else if (tmr_expired) begin
          result_d = RES_TIMEOUT; state_d = S_FINISH;
        end
`endif
      end
      S_DOOR: begin
        result_d = RES_VENDED; state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Timer reload on entry to every timed state
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_d != state_q) begin
      unique case (state_d)
        S_GAP_C, S_GAP_1, S_GAP_2: begin
          tmr_load = 1'b1; tmr_val = TMR_W'(GAP_LOAD);
        end
        S_WAIT_COST, S_AUTH, S_WAIT_VEND: begin
          tmr_load = 1'b1; tmr_val = TMR_W'(TIMEOUT_CYCLES);
        end
        S_DOOR_WAIT: begin
          tmr_load = 1'b1;
`ifdef VSEQ_AUTO_DOOR_EN
          tmr_val  = TMR_W'(DOOR_LOAD);
`else
          tmr_val  = TMR_W'(TIMEOUT_CYCLES);
`endif
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the next state so they register alongside it
  always_comb begin
    card_in_d    = (state_d == S_CARD);
    key_press_d  = (state_d == S_KEY1) || (state_d == S_KEY2);
    valid_tran_d = (state_d == S_PAY);
    door_open_d  = (state_d == S_DOOR);
    auth_req_d   = (state_d == S_AUTH);
    busy_d       = (state_d != S_IDLE) && (state_d != S_FINISH);
    done_d       = (state_d == S_FINISH);
    item_code_d  = '0;
    if (state_d == S_KEY1 || state_d == S_GAP_1) item_code_d = tens_d;
    if (state_d == S_KEY2 || state_d == S_GAP_2) item_code_d = units_d;
  end

  // FSM and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      result_q     <= RES_VENDED;
      tens_q       <= '0;
      units_q      <= '0;
      auth_amt_q   <= '0;
      item_code_q  <= '0;
      card_in_q    <= 1'b0;
      key_press_q  <= 1'b0;
      valid_tran_q <= 1'b0;
      door_open_q  <= 1'b0;
      auth_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      tens_q       <= tens_d;
      units_q      <= units_d;
      auth_amt_q   <= auth_amt_d;
      item_code_q  <= item_code_d;
      card_in_q    <= card_in_d;
      key_press_q  <= key_press_d;
      valid_tran_q <= valid_tran_d;
      door_open_q  <= door_open_d;
      auth_req_q   <= auth_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.CARD_IN    = card_in_q;
  assign bus.KEY_PRESS  = key_press_q;
  assign bus.VALID_TRAN = valid_tran_q;
  assign bus.DOOR_OPEN  = door_open_q;
  assign bus.ITEM_CODE  = item_code_q;
  assign bus.AUTH_REQ   = auth_req_q;
  assign bus.AUTH_AMT   = auth_amt_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.RESULT     = result_q;

endmodule

// File: tb/tb_vend_request_sequencer.sv
// Bench for vend_request_sequencer: directed test-plan transactions plus
// randomized machine/authorizer responses, checked cycle by cycle against a
// timeline model built from phase windows. Honors VSEQ_AUTO_DOOR_EN.
module tb_vend_request_sequencer;
  import vend_pkg::*;

  localparam int G  = 1;
  localparam int T  = 12;
  localparam int D  = 2;
  localparam int N  = 160;
  localparam int K1 = 2 + G;
  localparam int K2 = 3 + 2 * G;
  localparam int WC = 4 + 3 * G;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  vend_request_sequencer_if vif();

  vend_request_sequencer #(
    .GAP_CYCLES(G), .TIMEOUT_CYCLES(T), .DOOR_DELAY(D)
  ) dut (
    .CLK(CLK), .RESET(RESET), .bus(vif)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int ntx   = 0;

  // stimulus per cycle offset from the START cycle
  logic       inv_a  [N];
  logic       fail_a [N];
  logic [2:0] cost_a [N];
  logic       av_a   [N];
  logic       aok_a  [N];
  logic       vend_a [N];
  logic       take_a [N];

  // expected timeline of the current transaction
  int         m_fin, m_pay, m_door, m_a, m_aend;
  logic [1:0] m_res;
  logic [2:0] m_amt, m_amt_new;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {16'd0, vif.AUTH_AMT, vif.RESULT, vif.BUSY, vif.DONE, vif.CARD_IN,
            vif.KEY_PRESS, vif.VALID_TRAN, vif.DOOR_OPEN, vif.AUTH_REQ, vif.ITEM_CODE};
  endfunction

  function automatic logic [31:0] exp_at(input int c, input logic [3:0] tn, input logic [3:0] un);
    logic [3:0] item;
    logic [2:0] amt;
    logic [1:0] res;
    item = 4'd0;
    if (c >= K1 && c <= K1 + G) item = tn;
    else if (c >= K2 && c <= K2 + G) item = un;
    amt = (m_a >= 0 && c >= m_a) ? m_amt_new : m_amt;
    res = (c >= m_fin) ? m_res : 2'b00;
    return {16'd0, amt, res, (c < m_fin), (c == m_fin), (c == 1), (c == K1 || c == K2),
            (c == m_pay), (c == m_door), (m_a >= 0 && c >= m_a && c <= m_aend), item};
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      inv_a[i] = 1'b0; fail_a[i] = 1'b0; cost_a[i] = 3'd0; av_a[i] = 1'b0;
      aok_a[i] = 1'b0; vend_a[i] = 1'b0; take_a[i] = 1'b0;
    end
  endtask

  // Walk the response windows: each wait phase is open for T+1 cycles
  task automatic build_expect();
    int a, w, dw;
    a = -1; w = -1; dw = -1;
    m_a = -1; m_aend = -1; m_pay = -1; m_door = -1; m_fin = -1;
    m_res = 2'b00; m_amt_new = m_amt;
    for (int c = WC; c <= WC + T; c++) begin
      if (inv_a[c])  begin m_res = 2'b01; m_fin = c + 1; break; end
      if (fail_a[c]) begin m_res = 2'b10; m_fin = c + 1; break; end
      if (cost_a[c] != 3'd0) begin m_amt_new = cost_a[c]; a = c + 1; break; end
    end
    if (m_fin < 0 && a < 0) begin m_res = 2'b11; m_fin = WC + T + 1; end
    if (a >= 0) begin
      m_a = a;
      for (int c = a; c <= a + T; c++) begin
        if (fail_a[c]) begin m_aend = c; m_res = 2'b10; m_fin = c + 1; break; end
        if (av_a[c]) begin
          m_aend = c;
          if (aok_a[c]) m_pay = c + 1;
          else          w = c + 1;
          break;
        end
      end
      if (m_aend < 0) begin m_aend = a + T; m_res = 2'b11; m_fin = a + T + 1; end
    end
    if (m_pay >= 0) begin
      if (fail_a[m_pay]) begin m_res = 2'b10; m_fin = m_pay + 1; end
      else w = m_pay + 1;
    end
    if (w >= 0) begin
      for (int c = w; c <= w + T; c++) begin
        if (fail_a[c]) begin m_res = 2'b10; m_fin = c + 1; break; end
        if (vend_a[c]) begin dw = c + 1; break; end
      end
      if (m_fin < 0 && dw < 0) begin m_res = 2'b11; m_fin = w + T + 1; end
    end
    if (dw >= 0) begin
`ifdef VSEQ_AUTO_DOOR_EN
      m_door = dw + D;
`else
      for (int c = dw; c <= dw + T; c++) begin
        if (take_a[c]) begin m_door = c + 1; break; end
      end
      if (m_door < 0) begin m_res = 2'b11; m_fin = dw + T + 1; end
`endif
    end
    if (m_door >= 0) begin m_res = 2'b00; m_fin = m_door + 1; end
  endtask

  task automatic drive_cycle(input int c, input bit strobe, input logic [3:0] tn, input logic [3:0] un);
    vif.START       = strobe;
    vif.TENS        = (c == 0) ? tn : 4'($urandom);
    vif.UNITS       = (c == 0) ? un : 4'($urandom);
    vif.INVALID_SEL = inv_a[c];
    vif.FAILED_TRAN = fail_a[c];
    vif.COST        = cost_a[c];
    vif.AUTH_VALID  = av_a[c];
    vif.AUTH_OK     = aok_a[c];
    vif.VEND        = vend_a[c];
    vif.TAKE_ITEM   = take_a[c];
  endtask

  task automatic idle_inputs();
    vif.START = 1'b0; vif.TENS = 4'd0; vif.UNITS = 4'd0; vif.INVALID_SEL = 1'b0;
    vif.FAILED_TRAN = 1'b0; vif.COST = 3'd0; vif.AUTH_VALID = 1'b0; vif.AUTH_OK = 1'b0;
    vif.VEND = 1'b0; vif.TAKE_ITEM = 1'b0;
  endtask

  // One full transaction; entered and left just after a rising edge
  task automatic do_txn(input logic [3:0] tn, input logic [3:0] un, input bit restart);
    build_expect();
    for (int c = 0; c <= m_fin + 1; c++) begin
      drive_cycle(c, (c == 0) || (restart && c == K1), tn, un);
      @(negedge CLK);
      if (c >= 1) check_eq($sformatf("txn%0d_cyc%0d", ntx, c), obs(), exp_at(c, tn, un));
      @(posedge CLK);
      #1;
    end
    idle_inputs();
    if (m_a >= 0) m_amt = m_amt_new;
    $display("txn %0d item=%h%h restart=%0d result=%0d done_at=%0d", ntx, tn, un, restart, m_res, m_fin);
    ntx++;
  endtask

  task automatic gen_random();
    int cc, avt, vd;
    clear_stim();
    for (int c = 1; c < WC; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: inv_a[c] = 1'b1;
          1: fail_a[c] = 1'b1;
          2: cost_a[c] = 3'($urandom_range(1, 7));
          3: vend_a[c] = 1'b1;
          4: begin av_a[c] = 1'b1; aok_a[c] = 1'b1; end
          default: take_a[c] = 1'b1;
        endcase
      end
    end
    cc = WC + int'($urandom_range(0, T + 2));
    cost_a[cc] = 3'($urandom_range(1, 7));
    if ($urandom_range(0, 4) == 0) inv_a[WC + int'($urandom_range(0, T))] = 1'b1;
    if ($urandom_range(0, 4) == 0) fail_a[WC + int'($urandom_range(0, 50))] = 1'b1;
    avt = cc + 1 + int'($urandom_range(0, T + 2));
    av_a[avt]  = 1'b1;
    aok_a[avt] = ($urandom_range(0, 3) != 0);
    vd = avt + 2 + int'($urandom_range(0, T + 2));
    vend_a[vd] = 1'b1;
    if (!aok_a[avt] && $urandom_range(0, 1) == 1) fail_a[avt + 1 + int'($urandom_range(0, T))] = 1'b1;
    take_a[vd + 1 + int'($urandom_range(0, T + 2))] = 1'b1;
  endtask

  initial begin
    idle_inputs();
    m_amt = 3'd0;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("reset_state", obs(), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // item 17: full vend, cost 3
    clear_stim();
    cost_a[WC + 1] = 3'd3;
    av_a[WC + 3] = 1'b1; aok_a[WC + 3] = 1'b1;
    vend_a[WC + 7] = 1'b1;
    take_a[WC + 10] = 1'b1;
    do_txn(4'h1, 4'h7, 1'b0);

    // item 2F: invalid selection
    clear_stim();
    inv_a[WC + 2] = 1'b1;
    do_txn(4'h2, 4'hF, 1'b0);

    // item 01: declined, machine fails 5 cycles later
    clear_stim();
    cost_a[WC] = 3'd4;
    av_a[WC + 2] = 1'b1; aok_a[WC + 2] = 1'b0;
    fail_a[WC + 7] = 1'b1;
    do_txn(4'h0, 4'h1, 1'b0);

    // machine silent after KEY2
    clear_stim();
    do_txn(4'h5, 4'h9, 1'b0);

    // INVALID_SEL and COST=2 in the same cycle
    clear_stim();
    inv_a[WC + 1] = 1'b1; cost_a[WC + 1] = 3'd2;
    do_txn(4'h3, 4'h4, 1'b0);

    // START pulsed again during KEY1
    clear_stim();
    cost_a[WC + 2] = 3'd6;
    av_a[WC + 4] = 1'b1; aok_a[WC + 4] = 1'b1;
    vend_a[WC + 6] = 1'b1;
    take_a[WC + 8] = 1'b1;
    do_txn(4'h8, 4'h2, 1'b1);

    // randomized responses
    for (int i = 0; i < 40; i++) begin
      gen_random();
      do_txn(4'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0));
    end

    // RESET while waiting in AUTH: immediate abort, no DONE afterwards
    clear_stim();
    cost_a[WC] = 3'd5;
    for (int c = 0; c <= WC + 4; c++) begin
      drive_cycle(c, (c == 0), 4'h6, 4'h6);
      @(posedge CLK);
      #1;
    end
    idle_inputs();
    check_eq("auth_req_before_rst", {31'd0, vif.AUTH_REQ}, 32'd1);
    RESET = 1'b1;
    #1;
    check_eq("rst_mid_auth", obs(), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    m_amt = 3'd0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      check_eq($sformatf("post_rst_cyc%0d", c), obs(), 32'd0);
    end
    $display("txn %0d reset-abort in AUTH", ntx);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
